// File: rtl/shot_scheduler.sv
// Player shot sequencer: normal, burst and spread launches with frame-based
// gap and cooldown timing, handed to the bullet pool over valid/ready.
module shot_scheduler #(
  parameter int BURST_GAP = 4,
  parameter int CD_NORMAL = 15,
  parameter int CD_BURST  = 40,
  parameter int CD_SPREAD = 30,
  parameter int CNT_W     = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       fire,
  input  logic [3:0] angle,
  input  logic       switch_shooting_mode1,
  input  logic       switch_shooting_mode2,
  input  logic       gameover,
  output logic       spawn_valid,
  output logic [3:0] spawn_angle,
  input  logic       spawn_ready,
  output logic       busy,
  output logic [2:0] shooting_led
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    COOLDOWN
  } state_t;

  localparam logic [CNT_W-1:0] GAP_LD = CNT_W'(BURST_GAP);
  localparam logic [CNT_W-1:0] CD_N   = CNT_W'(CD_NORMAL);
  localparam logic [CNT_W-1:0] CD_B   = CNT_W'(CD_BURST);
  localparam logic [CNT_W-1:0] CD_S   = CNT_W'(CD_SPREAD);
  localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);

  state_t           state;
  logic [1:0]       mode_q;
  logic [1:0]       shot_idx;
  logic [3:0]       angle_q;
  logic [CNT_W-1:0] cnt;

  logic [1:0]       mode_live;
  logic [2:0]       led_live;
  logic [1:0]       last_idx;
  logic [1:0]       next_idx;
  logic [3:0]       shot_ang;
  logic [3:0]       next_ang;
  logic [CNT_W-1:0] cd_ld;

  assign mode_live = {switch_shooting_mode1, switch_shooting_mode2};

  always_comb begin
    led_live = 3'b111;
    unique case (1'b1)
      mode_live == 2'b10: led_live = 3'b011;
      mode_live == 2'b11: led_live = 3'b001;
      default:            led_live = 3'b111;
    endcase
  end

  always_comb begin
    cd_ld = CD_N;
    unique case (1'b1)
      mode_q == 2'b10: cd_ld = CD_B;
      mode_q == 2'b11: cd_ld = CD_S;
      default:         cd_ld = CD_N;
    endcase
  end

  // Burst and spread fire three shots, normal modes a single one.
  assign last_idx = mode_q[1] ? 2'd2 : 2'd0;
  assign next_idx = shot_idx + 2'd1;

  // Spread fans out angle-1, angle, angle+1; 4-bit math gives the wrap.
  assign shot_ang = (mode_q == 2'b11)
                  ? angle_q + {2'b00, shot_idx} - 4'd1
                  : angle_q;
  assign next_ang = (mode_q == 2'b11)
                  ? angle_q + {2'b00, next_idx} - 4'd1
                  : angle_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      mode_q       <= 2'b00;
      angle_q      <= 4'd0;
      shot_idx     <= 2'd0;
      cnt          <= '0;
      spawn_valid  <= 1'b0;
      spawn_angle  <= 4'd0;
      busy         <= 1'b0;
      shooting_led <= 3'b000;
    end else if (gameover) begin
      state        <= IDLE;
      shot_idx     <= 2'd0;
      cnt          <= '0;
      spawn_valid  <= 1'b0;
      busy         <= 1'b0;
      shooting_led <= 3'b000;
    end else begin
      shooting_led <= 3'b000;
      unique case (state)
        IDLE: begin
          if (fire) begin
            mode_q   <= mode_live;
            angle_q  <= angle;
            shot_idx <= 2'd0;
            state    <= ISSUE;
            busy     <= 1'b1;
          end else begin
            shooting_led <= led_live;
          end
        end
        ISSUE: begin
          if (!spawn_valid) begin
            spawn_valid <= 1'b1;
            spawn_angle <= shot_ang;
          end else if (spawn_ready) begin
            if (shot_idx != last_idx) begin
              shot_idx <= next_idx;
              if (mode_q[0]) begin
                spawn_angle <= next_ang;
              end else begin
                spawn_valid <= 1'b0;
                state       <= GAP;
                cnt         <= GAP_LD;
              end
            end else begin
              spawn_valid <= 1'b0;
              state       <= COOLDOWN;
              cnt         <= cd_ld;
            end
          end
        end
        GAP: begin
          if (cnt == '0) begin
            state <= ISSUE;
          end else if (frame_tick) begin
            cnt <= cnt - ONE;
          end
        end
        COOLDOWN: begin
          if (cnt == '0) begin
            state        <= IDLE;
            busy         <= 1'b0;
            shooting_led <= led_live;
          end else if (frame_tick) begin
            cnt <= cnt - ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shot_scheduler.sv
// Bench for shot_scheduler: LED table, hand-written shot sequences and
// randomized traffic against a queue-based reference model.
module tb_shot_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       fire;
  logic [3:0] angle;
  logic       sw1;
  logic       sw2;
  logic       gameover;
  logic       spawn_valid;
  logic [3:0] spawn_angle;
  logic       spawn_ready;
  logic       busy;
  logic [2:0] shooting_led;

  shot_scheduler dut (
    .clk                  (clk),
    .reset                (reset),
    .frame_tick           (frame_tick),
    .fire                 (fire),
    .angle                (angle),
    .switch_shooting_mode1(sw1),
    .switch_shooting_mode2(sw2),
    .gameover             (gameover),
    .spawn_valid          (spawn_valid),
    .spawn_angle          (spawn_angle),
    .spawn_ready          (spawn_ready),
    .busy                 (busy),
    .shooting_led         (shooting_led)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  typedef struct {
    logic       m1;
    logic       m2;
    logic       go;
    logic [2:0] led;
  } led_vec_t;

  led_vec_t tbl [8];

  bit         m_busy;
  bit         m_valid;
  bit         m_waiting;
  bit         m_to_idle;
  int         m_wait;
  logic [3:0] m_angle;
  logic [2:0] m_led;
  logic [1:0] m_mode;
  logic [3:0] plan [$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic fire_pulse();
    fire = 1'b1;
    cyc();
    fire = 1'b0;
  endtask

  // Ticks one frame every third cycle; counts ticks until the stop event.
  task automatic count_ticks(input bit until_valid, output int n);
    int k;
    n = 0;
    for (k = 0; k < 3000; k++) begin
      if (until_valid ? spawn_valid : !busy) break;
      frame_tick = (k % 3 == 2);
      if (frame_tick) n++;
      cyc();
    end
    frame_tick = 1'b0;
    if (k == 3000) n = -1;
  endtask

  function automatic logic [2:0] led_of(input logic [1:0] m);
    if (m == 2'b10) return 3'b011;
    if (m == 2'b11) return 3'b001;
    return 3'b111;
  endfunction

  function automatic int cd_of(input logic [1:0] m);
    if (m == 2'b10) return 40;
    if (m == 2'b11) return 30;
    return 15;
  endfunction

  // Reference: a fire turns into a plan of angles that is drained by
  // transfers, with frame waits between burst shots and after the plan.
  task automatic model_step();
    logic [3:0] t;
    if (!reset) begin
      m_busy = 0; m_valid = 0; m_waiting = 0;
      m_angle = 4'd0; m_led = 3'b000;
      plan.delete();
    end else if (gameover) begin
      m_busy = 0; m_valid = 0; m_waiting = 0;
      m_led = 3'b000;
      plan.delete();
    end else if (!m_busy) begin
      if (fire) begin
        m_mode = {sw1, sw2};
        plan.delete();
        if (m_mode == 2'b10) begin
          repeat (3) plan.push_back(angle);
        end else if (m_mode == 2'b11) begin
          t = angle - 4'd1; plan.push_back(t);
          plan.push_back(angle);
          t = angle + 4'd1; plan.push_back(t);
        end else begin
          plan.push_back(angle);
        end
        m_busy = 1;
        m_led = 3'b000;
      end else begin
        m_led = led_of({sw1, sw2});
      end
    end else if (m_waiting) begin
      if (m_wait == 0) begin
        m_waiting = 0;
        if (m_to_idle) begin
          m_busy = 0;
          m_led = led_of({sw1, sw2});
        end
      end else if (frame_tick) begin
        m_wait--;
      end
    end else if (!m_valid) begin
      m_valid = 1;
      m_angle = plan[0];
    end else if (spawn_ready) begin
      void'(plan.pop_front());
      m_valid = 0;
      if (plan.size() == 0) begin
        m_waiting = 1; m_to_idle = 1; m_wait = cd_of(m_mode);
      end else if (m_mode == 2'b11) begin
        m_valid = 1;
        m_angle = plan[0];
      end else begin
        m_waiting = 1; m_to_idle = 0; m_wait = 4;
      end
    end
  endtask

  initial begin
    int n;
    int hits;
    tbl[0] = '{1'b0, 1'b0, 1'b0, 3'b111};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 3'b111};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 3'b011};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 3'b001};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 3'b000};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 3'b011};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 3'b000};
    tbl[7] = '{1'b0, 1'b1, 1'b0, 3'b111};

    reset = 1'b0; frame_tick = 1'b0; fire = 1'b0; angle = 4'd0;
    sw1 = 1'b0; sw2 = 1'b0; gameover = 1'b0; spawn_ready = 1'b0;
    repeat (3) cyc();
    chk("rst_out", {spawn_valid, spawn_angle, busy, shooting_led}, 0);
    reset = 1'b1;
    cyc();
    chk("rst_rel_led", shooting_led, 7);
    chk("rst_rel_ctl", {spawn_valid, busy}, 0);

    for (int i = 0; i < 8; i++) begin
      sw1 = tbl[i].m1; sw2 = tbl[i].m2; gameover = tbl[i].go;
      cyc();
      chk($sformatf("led_tbl%0d", i), shooting_led, tbl[i].led);
      chk($sformatf("busy_tbl%0d", i), busy, 0);
    end
    gameover = 1'b0;
    cyc();

    // normal shot
    sw1 = 0; sw2 = 0; angle = 4'd5; spawn_ready = 1;
    fire_pulse();
    chk("norm_lat", {spawn_valid, busy}, 1);
    cyc();
    chk("norm_valid", {spawn_valid, spawn_angle}, 16 + 5);
    cyc();
    chk("norm_done", {spawn_valid, busy}, 1);
    count_ticks(0, n);
    chk("norm_cd", n, 15);
    chk("norm_led", shooting_led, 7);

    // spread, angle 0
    sw1 = 1; sw2 = 1; angle = 4'd0;
    fire_pulse();
    chk("spr_lat", spawn_valid, 0);
    cyc();
    chk("spr_a0", {spawn_valid, spawn_angle}, 16 + 15);
    cyc();
    chk("spr_a1", {spawn_valid, spawn_angle}, 16 + 0);
    cyc();
    chk("spr_a2", {spawn_valid, spawn_angle}, 16 + 1);
    cyc();
    chk("spr_end", {spawn_valid, busy}, 1);
    count_ticks(0, n);
    chk("spr_cd", n, 30);

    // burst, switches and angle disturbed mid-burst
    sw1 = 1; sw2 = 0; angle = 4'd9;
    fire_pulse();
    sw1 = 1; sw2 = 1; angle = 4'd3;
    cyc();
    chk("bst_s0", {spawn_valid, spawn_angle}, 16 + 9);
    cyc();
    chk("bst_g0", spawn_valid, 0);
    count_ticks(1, n);
    chk("bst_gap1", n, 4);
    chk("bst_s1", spawn_angle, 9);
    cyc();
    chk("bst_g1", spawn_valid, 0);
    count_ticks(1, n);
    chk("bst_gap2", n, 4);
    chk("bst_s2", spawn_angle, 9);
    cyc();
    chk("bst_end", {spawn_valid, busy}, 1);
    count_ticks(0, n);
    chk("bst_cd", n, 40);
    chk("bst_led", shooting_led, 1);

    // back-pressure
    sw1 = 0; sw2 = 0; angle = 4'd7; spawn_ready = 0;
    fire_pulse();
    cyc();
    chk("stall_v", {spawn_valid, spawn_angle}, 16 + 7);
    angle = 4'd2;
    hits = 0;
    repeat (10) begin
      cyc();
      if (spawn_valid && spawn_angle == 4'd7) hits++;
    end
    chk("stall_hold", hits, 10);
    spawn_ready = 1;
    cyc();
    chk("stall_xfer", {spawn_valid, busy}, 1);
    gameover = 1;
    cyc();
    chk("go_cd", {spawn_valid, busy, shooting_led}, 0);
    gameover = 0;
    cyc();
    chk("go_cd_led", shooting_led, 7);

    // auto-repeat with a tick every cycle
    angle = 4'd1; fire = 1;
    cyc();
    cyc();
    chk("rep_v", spawn_valid, 1);
    frame_tick = 1;
    cyc();
    n = 0;
    while (!spawn_valid && n < 100) begin
      cyc();
      n++;
    end
    chk("rep_gap", n, 18);
    fire = 0; frame_tick = 0;
    cyc();
    gameover = 1;
    cyc();
    gameover = 0;
    cyc();

    // gameover during a burst, fire held
    sw1 = 1; sw2 = 0; angle = 4'd4; fire = 1;
    cyc();
    cyc();
    chk("go_b_v", spawn_valid, 1);
    cyc();
    chk("go_b_x", {spawn_valid, busy}, 1);
    gameover = 1;
    cyc();
    chk("go_b_idle", {spawn_valid, busy, shooting_led}, 0);
    hits = 0;
    repeat (10) begin
      cyc();
      if (spawn_valid || busy || shooting_led != 3'b000) hits++;
    end
    chk("go_b_hold", hits, 0);
    gameover = 0; fire = 0;
    cyc();
    chk("go_b_led", shooting_led, 3);

    // gameover withdraws a pending spawn
    sw1 = 1; sw2 = 1; angle = 4'd8; spawn_ready = 0;
    fire_pulse();
    cyc();
    chk("go_s_v", {spawn_valid, spawn_angle}, 16 + 7);
    gameover = 1;
    cyc();
    chk("go_s_drop", {spawn_valid, busy}, 0);
    gameover = 0;
    cyc();

    for (int c = 0; c < 6000; c++) begin
      reset = !(c < 2 || $urandom_range(0, 399) == 0);
      gameover = ($urandom_range(0, 149) == 0);
      fire = ($urandom_range(0, 99) < 35);
      spawn_ready = ($urandom_range(0, 99) < 60);
      frame_tick = ($urandom_range(0, 99) < 40);
      angle = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 9) == 0) {sw1, sw2} = 2'($urandom_range(0, 3));
      model_step();
      cyc();
      chk("rand_ctl", {spawn_valid, busy, shooting_led},
          {m_valid, m_busy, m_led});
      if (m_valid) chk("rand_ang", spawn_angle, m_angle);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
